// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
// Also used by the peripheral multiplexer's picker.
package mem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  function automatic logic [2:0] onehot_to_index(
    input logic [7:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection: fixed priority or
// round-robin starting at ptr.
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int MODE  = ARB_RR,
  localparam int IW   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  logic [2*PORTS-1:0] dbl;
  logic [PORTS-1:0]   rot;
  int                 base;

  // Rotate so that bit 0 is the port at ptr; first set bit wins.
  always_comb begin
    dbl    = {req, req};
    base   = 0;
    rot    = req;
    winner = '0;
    valid  = |req;
    if (MODE == ARB_RR) begin
      base = int'(ptr);
      rot  = PORTS'(dbl >> ptr);
    end
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (rot[i]) winner = IW'((base + i) % PORTS);
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port arbiter in front of one SDRAM controller port.
// Optional burst watchdog: MEM_ARB_WATCHDOG_EN.
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter int PORTS       = 4,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PORTS-1:0]         m_req,
  input  logic [PORTS*ADDR_W-1:0]  m_addr,
  input  logic [PORTS-1:0]         m_we,
  input  logic [PORTS*DATA_W-1:0]  m_wdata,
  output logic [PORTS-1:0]         m_grant,
  output logic [PORTS-1:0]         m_ack,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic [ADDR_W-1:0]        s_addr,
  output logic                     s_we,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_ack,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic                     last_word,
  output logic                     busy
`ifdef MEM_ARB_WATCHDOG_EN
  ,
  output logic                     wd_fault,
  output logic [2:0]               wd_port
`endif
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 2 || PORTS > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("mem_arbiter_n: unsupported parameters");
  end

  arb_state_t       state;
  logic [PORTS-1:0] grant;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    ptr_nxt;
  logic             valid;
  logic             rel;
  logic             wd_hit;
  logic [7:0]       grant8;

  arb_picker #(
    .PORTS (PORTS),
    .MODE  (ROUND_ROBIN)
  ) u_picker (
    .req    (m_req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (valid)
  );

  always_comb begin
    grant8             = '0;
    grant8[PORTS-1:0]  = grant;
  end

  assign owner   = IW'(onehot_to_index(grant8));
  assign ptr_nxt = (owner == IW'(PORTS - 1)) ? '0 : owner + 1'b1;
  assign busy    = (state == ARB_BUSY);
  assign rel     = busy && (last_word || wd_hit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (valid) begin
            grant <= PORTS'(1) << winner;
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Release always passes through one idle cycle.
          if (rel) begin
            grant <= '0;
            ptr   <= ptr_nxt;
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    m_grant = grant;
    m_rdata = s_rdata;
    s_req   = busy && |(m_req & grant);
    s_we    = busy && |(m_we & grant);
    m_ack   = (busy && s_ack) ? grant : '0;
    s_addr  = '0;
    s_wdata = '0;
    if (busy) begin
      s_addr  = m_addr[owner*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[owner*DATA_W +: DATA_W];
    end
  end

`ifdef MEM_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;

  assign wd_hit   = busy && !last_word &&
                    (wd_cnt == 16'(TIMEOUT - 1));
  assign wd_fault = wd_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      wd_port <= '0;
    end else begin
      if (!busy) wd_cnt <= '0;
      else if (!last_word) wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) wd_port <= onehot_to_index(grant8);
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: round-robin and fixed-priority
// instances on shared stimulus, checked against a model.
module tb_mem_arbiter_n;

  localparam int P  = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [P-1:0]  m_req;
  logic [P*AW-1:0] m_addr;
  logic [P-1:0]  m_we;
  logic [P*DW-1:0] m_wdata;
  logic          s_ack;
  logic [DW-1:0] s_rdata;
  logic          last_word;

  logic [P-1:0]  rr_grant, fx_grant, rr_ack, fx_ack;
  logic [DW-1:0] rr_rdata, fx_rdata, rr_swd, fx_swd;
  logic [AW-1:0] rr_saddr, fx_saddr;
  logic          rr_sreq, fx_sreq, rr_swe, fx_swe;
  logic          rr_busy, fx_busy;
`ifdef MEM_ARB_WATCHDOG_EN
  logic          rr_wdf, fx_wdf;
  logic [2:0]    rr_wdp, fx_wdp;
`endif

  mem_arbiter_n #(
    .PORTS(P), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1)
  ) u_rr (
    .clock(clk), .reset(rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_grant(rr_grant), .m_ack(rr_ack),
    .m_rdata(rr_rdata), .s_req(rr_sreq), .s_addr(rr_saddr),
    .s_we(rr_swe), .s_wdata(rr_swd), .s_ack(s_ack),
    .s_rdata(s_rdata), .last_word(last_word), .busy(rr_busy)
`ifdef MEM_ARB_WATCHDOG_EN
    , .wd_fault(rr_wdf), .wd_port(rr_wdp)
`endif
  );

  mem_arbiter_n #(
    .PORTS(P), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0)
  ) u_fx (
    .clock(clk), .reset(rst),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_grant(fx_grant), .m_ack(fx_ack),
    .m_rdata(fx_rdata), .s_req(fx_sreq), .s_addr(fx_saddr),
    .s_we(fx_swe), .s_wdata(fx_swd), .s_ack(s_ack),
    .s_rdata(s_rdata), .last_word(last_word), .busy(fx_busy)
`ifdef MEM_ARB_WATCHDOG_EN
    , .wd_fault(fx_wdf), .wd_port(fx_wdp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Model: index 0 = round-robin instance, 1 = fixed.
  int own[2];
  int ptr[2];
  int rr_q[$];
  int fx_q[$];
  logic [P-1:0] prev_rr, prev_fx;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [P-1:0] r, int p, bit rr);
    for (int k = 0; k < P; k++) begin
      int idx;
      idx = rr ? (p + k) % P : k;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int oh_idx(logic [P-1:0] g);
    for (int i = 0; i < P; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic check_inst(string nm, int m,
    logic [P-1:0] g, logic sr, logic [AW-1:0] sa,
    logic swe, logic [DW-1:0] swd, logic [P-1:0] ack,
    logic [DW-1:0] rd, logic bsy);
    logic [P-1:0]  eg;
    logic [P-1:0]  eack;
    logic          esr, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int o;
    o = own[m];
    eg = '0; eack = '0; esr = 0; ewe = 0; ea = '0; ed = '0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      esr   = m_req[o];
      ewe   = m_we[o];
      ea    = m_addr[o*AW +: AW];
      ed    = m_wdata[o*DW +: DW];
      if (s_ack) eack[o] = 1'b1;
    end
    chk({nm, "_grant"}, g, eg);
    chk({nm, "_busy"}, bsy, o >= 0);
    chk({nm, "_s_req"}, sr, esr);
    chk({nm, "_s_addr"}, sa, ea);
    chk({nm, "_s_we"}, swe, ewe);
    chk({nm, "_s_wdata"}, swd, ed);
    chk({nm, "_m_ack"}, ack, eack);
    chk({nm, "_m_rdata"}, rd, s_rdata);
  endtask

  task automatic step();
    #1;
    check_inst("rr", 0, rr_grant, rr_sreq, rr_saddr, rr_swe,
               rr_swd, rr_ack, rr_rdata, rr_busy);
    check_inst("fx", 1, fx_grant, fx_sreq, fx_saddr, fx_swe,
               fx_swd, fx_ack, fx_rdata, fx_busy);
    if (rr_grant != 0 && prev_rr == 0)
      rr_q.push_back(oh_idx(rr_grant));
    if (fx_grant != 0 && prev_fx == 0)
      fx_q.push_back(oh_idx(fx_grant));
    prev_rr = rr_grant;
    prev_fx = fx_grant;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (own[m] < 0) begin
        own[m] = pick(m_req, ptr[m], m == 0);
      end else if (last_word) begin
        if (m == 0) ptr[m] = (own[m] + 1) % P;
        own[m] = -1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int bcnt;
    int cnt3;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    own = '{-1, -1};
    ptr = '{0, 0};
    prev_rr = '0;
    prev_fx = '0;
    rst = 1'b1;
    m_req = 4'b1111;
    m_addr = '0;
    m_we = '0;
    m_wdata = '0;
    s_ack = 1'b0;
    s_rdata = '0;
    last_word = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_rr_grant", rr_grant, 4'b0000);
      chk("rst_fx_grant", fx_grant, 4'b0000);
      chk("rst_rr_s_req", rr_sreq, 1'b0);
      chk("rst_rr_busy", rr_busy, 1'b0);
    end
    rst = 1'b0;
    step();
    #1;
    chk("post_rst_rr_grant", rr_grant, 4'b0001);
    chk("post_rst_fx_grant", fx_grant, 4'b0001);

    // Round-robin: all ports request, bursts of 4 words.
    bcnt = 0;
    for (int c = 0; c < 60 && rr_q.size() < 5; c++) begin
      if (own[0] >= 0) bcnt++;
      else bcnt = 0;
      last_word = (bcnt == 4);
      step();
    end
    chk("rr_seq_len", rr_q.size(), 5);
    for (int i = 0; i < 5 && i < rr_q.size(); i++)
      chk("rr_seq", rr_q[i], exp_rr[i]);

    // Fixed priority with ports 1 and 3 requesting.
    m_req = 4'b1010;
    fx_q.delete();
    for (int c = 0; c < 100 && fx_q.size() < 6; c++) begin
      if (own[1] >= 0) bcnt++;
      else bcnt = 0;
      last_word = (bcnt >= 4);
      step();
    end
    chk("fx_grants", fx_q.size(), 6);
    cnt3 = 0;
    foreach (fx_q[i]) begin
      chk("fx_port1", fx_q[i], 1);
      if (fx_q[i] == 3) cnt3++;
    end
    chk("fx_no_port3", cnt3, 0);

    // Drain to idle.
    m_req = '0;
    last_word = 1'b1;
    repeat (2) step();
    last_word = 1'b0;
    step();

    // Owner 2 drops its request mid-burst.
    m_req = 4'b0100;
    repeat (2) step();
    m_req = 4'b0000;
    repeat (2) begin
      #1;
      chk("drop_rr_grant", rr_grant, 4'b0100);
      chk("drop_rr_s_req", rr_sreq, 1'b0);
      chk("drop_fx_grant", fx_grant, 4'b0100);
      step();
    end
    m_req = 4'b0100;
    step();
    m_req = 4'b0000;
    last_word = 1'b1;
    step();
    last_word = 1'b0;
    #1;
    chk("drop_release", rr_grant, 4'b0000);
    step();

    // Release and a new request in the same cycle.
    m_req = 4'b0100;
    repeat (2) step();
    m_req = 4'b1000;
    last_word = 1'b1;
    step();
    last_word = 1'b0;
    #1;
    chk("coll_idle_rr", rr_grant, 4'b0000);
    chk("coll_idle_fx", fx_grant, 4'b0000);
    step();
    #1;
    chk("coll_grant_rr", rr_grant, 4'b1000);
    chk("coll_grant_fx", fx_grant, 4'b1000);
    last_word = 1'b1;
    step();
    last_word = 1'b0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      m_req = P'($urandom);
      m_we = P'($urandom);
      m_addr = {$urandom(), $urandom(), $urandom()};
      m_wdata = {$urandom(), $urandom()};
      s_ack = 1'($urandom);
      s_rdata = DW'($urandom);
      last_word = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
